dual_port_mem_responder: RTL and testbench



---
 rtl/dual_port_mem_responder.sv | 137 +++++++++++++
 tb/tb_dual_port_mem_responder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dual_port_mem_responder.sv
// Memory-side responder for the core's two-port bundle: port 0 is the MEM-stage
// data port (read/write) and port 1 is the IF fetch port (read-only). Both ports
// share one word-organised single-port RAM through a round-robin arbiter. Each
// access sits through LATENCY wait states and then raises a one-cycle valid pulse.
module dual_port_mem_responder #(
  parameter int BITSIZE   = 32,
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 resetn_i,
  input  logic [2*BITSIZE-1:0] MEM_addr_i,
  input  logic [2*BITSIZE-1:0] MEM_data_i,
  output logic [2*BITSIZE-1:0] MEM_data_o,
  input  logic [1:0]           MEM_read_i,
  input  logic [1:0]           MEM_write_i,
  input  logic [3:0]           MEM_write_size_i,
  output logic [1:0]           MEM_valid_o
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // One granted access: everything needed to perform it at the access edge.
  typedef struct packed {
    logic               port;
    logic               wr;
    logic [AW-1:0]      idx;
    logic [1:0]         lane;
    logic [1:0]         size;
    logic [BITSIZE-1:0] data;
  } acc_t;

  state_t state, state_n;
  logic   ptr;
  logic [CW-1:0] cnt;
  acc_t   lat, new_acc, cur;
  logic   gnt_new, acc_en, acc_fire;
  logic [1:0] req;
  logic [1:0][BITSIZE-1:0] addr_v, wdat_v;
  logic [BITSIZE-1:0] ram [MEM_WORDS];
  logic [BITSIZE-1:0] dout [2];

  assign addr_v = MEM_addr_i;
  assign wdat_v = MEM_data_i;
  assign req    = {MEM_read_i[1], MEM_read_i[0] | MEM_write_i[0]};

  // Address bits above the RAM index, the port-1 write lane and port-1 write
  // controls have no function; fold them into a sink so they stay visible.
  logic unused_bits;
  assign unused_bits = ^{addr_v[0][BITSIZE-1:AW+2], addr_v[1][BITSIZE-1:AW+2],
                         wdat_v[1], MEM_write_i[1], MEM_write_size_i[3:2]};

  // Arbitration and capture of the access that would be granted this cycle.
  always_comb begin
    gnt_new       = (req == 2'b11) ? ptr : req[1];
    new_acc       = '0;
    new_acc.port  = gnt_new;
    new_acc.wr    = ~gnt_new & MEM_write_i[0];
    new_acc.idx   = addr_v[gnt_new][AW+1:2];
    new_acc.lane  = addr_v[gnt_new][1:0];
    new_acc.size  = gnt_new ? 2'b10 : MEM_write_size_i[1:0];
    new_acc.data  = wdat_v[0];
  end

  // With zero latency the access happens on the grant edge, so use the live request.
  assign cur = (state == IDLE) ? new_acc : lat;

  // Next state and access strobe.
  always_comb begin
    state_n = state;
    acc_en  = 1'b0;
    unique case (state)
      IDLE: if (|req) begin
        state_n = (LATENCY == 0) ? RESP : WAIT;
        acc_en  = (LATENCY == 0);
      end
      WAIT: begin
        if (!req[lat.port]) begin
          state_n = IDLE;                 // initiator withdrew (e.g. IF flush)
        end else if (cnt == CW'(1)) begin
          state_n = RESP;
          acc_en  = 1'b1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Never let an access slip through while reset is held.
  assign acc_fire = acc_en & resetn_i;

  // State, round-robin pointer, latched request and wait counter.
  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      state <= IDLE;
      ptr   <= 1'b0;
      cnt   <= '0;
      lat   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && |req) begin
        lat <= new_acc;
        cnt <= CW'(LATENCY);
        if (req == 2'b11) ptr <= ~ptr;
      end else if (state == WAIT && req[lat.port] && cnt != CW'(1)) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  // RAM write port with byte/half/word merge; contents survive reset.
  always_ff @(posedge clk) begin
    if (acc_fire && cur.wr) begin
      unique case (cur.size)
        2'b00:   ram[cur.idx][cur.lane*8 +: 8]     <= cur.data[7:0];
        2'b01:   ram[cur.idx][cur.lane[1]*16 +: 16] <= cur.data[15:0];
        default: ram[cur.idx]                      <= cur.data;
      endcase
    end
  end

  // Per-port read lanes: registered full word, held until that port reads again.
  for (genvar p = 0; p < 2; p++) begin : g_lane
    always_ff @(posedge clk or negedge resetn_i) begin
      if (!resetn_i)                                     dout[p] <= '0;
      else if (acc_fire && !cur.wr && cur.port == 1'(p)) dout[p] <= ram[cur.idx];
    end
  end

  assign MEM_data_o  = {dout[1], dout[0]};
  assign MEM_valid_o = (state == RESP) ? (lat.port ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_dual_port_mem_responder.sv
// Directed bench: instance 0 uses LATENCY=2, instance 1 uses LATENCY=3.
module tb_dual_port_mem_responder;

  logic        clk;
  logic        rst_n [2];
  logic [63:0] addr  [2];
  logic [63:0] wdata [2];
  logic [63:0] rdata [2];
  logic [1:0]  rd    [2];
  logic [1:0]  wr    [2];
  logic [1:0]  valid [2];
  logic [3:0]  sz    [2];

  int n_chk  = 0;
  int n_pass = 0;

  dual_port_mem_responder #(.BITSIZE(32), .MEM_WORDS(4096), .LATENCY(2)) u_l2 (
    .clk(clk), .resetn_i(rst_n[0]), .MEM_addr_i(addr[0]), .MEM_data_i(wdata[0]),
    .MEM_data_o(rdata[0]), .MEM_read_i(rd[0]), .MEM_write_i(wr[0]),
    .MEM_write_size_i(sz[0]), .MEM_valid_o(valid[0]));

  dual_port_mem_responder #(.BITSIZE(32), .MEM_WORDS(4096), .LATENCY(3)) u_l3 (
    .clk(clk), .resetn_i(rst_n[1]), .MEM_addr_i(addr[1]), .MEM_data_i(wdata[1]),
    .MEM_data_o(rdata[1]), .MEM_read_i(rd[1]), .MEM_write_i(wr[1]),
    .MEM_write_size_i(sz[1]), .MEM_valid_o(valid[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int d);
    rst_n[d] = 1'b0;
    tick(); tick();
    rst_n[d] = 1'b1;
  endtask

  // One access on instance d, port p; checks latency, exclusive valid and pulse width.
  task automatic access(input int d, input bit p, input bit w, input bit rw_both,
                        input logic [31:0] a, input logic [31:0] dat,
                        input logic [1:0] s, input int exp_lat, input string tag);
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    if (!p) begin
      addr[d][31:0]  = a;
      wdata[d][31:0] = dat;
      sz[d][1:0]     = s;
      rd[d][0]       = !w | rw_both;
      wr[d][0]       = w;
    end else begin
      addr[d][63:32] = a;
      rd[d][1]       = 1'b1;
    end
    while (!got && n < 30) begin
      tick();
      n++;
      if (valid[d][p]) got = 1'b1;
    end
    chk({tag, " latency"}, 64'(n), 64'(exp_lat));
    chk({tag, " valid"}, 64'(valid[d]), p ? 64'h2 : 64'h1);
    rd[d] = 2'b00;
    wr[d] = 2'b00;
    tick();
    chk({tag, " pulse"}, 64'(valid[d]), 64'h0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
      rd[d] = '0; wr[d] = '0; sz[d] = '0;
    end
    tick();
    chk("reset valid l2", 64'(valid[0]), 64'h0);
    chk("reset data l2", rdata[0], 64'h0);
    chk("reset valid l3", 64'(valid[1]), 64'h0);
    chk("reset data l3", rdata[1], 64'h0);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    tick();

    // Seed word 4 through port 0, fetch it through port 1.
    access(0, 0, 1, 0, 32'h10, 32'h1122_3344, 2'b10, 3, "p0 wr 0x10");
    access(0, 1, 0, 0, 32'h10, 32'h0, 2'b00, 3, "p1 rd 0x10");
    chk("p1 rd data", rdata[0], 64'h1122_3344_0000_0000);

    // Word write then read on port 0; port 1 lane untouched.
    access(0, 0, 1, 0, 32'h20, 32'hDEAD_BEEF, 2'b10, 3, "p0 wr 0x20");
    access(0, 0, 0, 0, 32'h20, 32'h0, 2'b00, 3, "p0 rd 0x20");
    chk("word rd data", rdata[0], 64'h1122_3344_DEAD_BEEF);

    // Writes leave the read lane alone; then byte and half merges.
    access(0, 0, 1, 0, 32'h20, 32'h1122_3344, 2'b11, 3, "p0 wr base");
    chk("write keeps lane", rdata[0], 64'h1122_3344_DEAD_BEEF);
    access(0, 0, 1, 0, 32'h23, 32'h0000_00AA, 2'b00, 3, "p0 wr byte");
    access(0, 0, 0, 0, 32'h20, 32'h0, 2'b00, 3, "p0 rd byte");
    chk("byte merge", rdata[0][31:0], 64'hAA22_3344);
    access(0, 0, 1, 0, 32'h22, 32'h0000_5566, 2'b01, 3, "p0 wr half");
    access(0, 0, 0, 0, 32'h20, 32'h0, 2'b00, 3, "p0 rd half");
    chk("half merge", rdata[0][31:0], 64'h5566_3344);

    // Read+write together: write wins. Address wrap modulo RAM size.
    access(0, 0, 1, 1, 32'h30, 32'h1234_5678, 2'b10, 3, "p0 rd+wr");
    access(0, 0, 0, 0, 32'h30, 32'h0, 2'b00, 3, "p0 rd 0x30");
    chk("write wins", rdata[0][31:0], 64'h1234_5678);
    access(0, 0, 1, 0, 32'h4020, 32'hCAFE_F00D, 2'b10, 3, "p0 wr wrap");
    access(0, 0, 0, 0, 32'h20, 32'h0, 2'b00, 3, "p0 rd wrap");
    chk("addr wrap", rdata[0][31:0], 64'hCAFE_F00D);

    // Both ports hammer from a fresh reset: p0, p1, p0, p1 every 4 cycles.
    do_reset(0);
    addr[0] = {32'h10, 32'h20};
    rd[0]   = 2'b11;
    for (int c = 0; c <= 16; c++) begin
      chk($sformatf("rr c%0d", c), 64'(valid[0]),
          (c == 3 || c == 11) ? 64'h1 : (c == 7 || c == 15) ? 64'h2 : 64'h0);
      tick();
    end
    rd[0] = 2'b00;
    chk("rr data", rdata[0], 64'h1122_3344_CAFE_F00D);

    // LATENCY=3: port 1 aborts after one wait cycle; pending port 0 goes next.
    access(1, 0, 1, 0, 32'h40, 32'h0102_0304, 2'b10, 4, "l3 wr 0x40");
    for (int c = 0; c <= 8; c++) begin
      if (c == 0) begin addr[1][63:32] = 32'h40; rd[1][1] = 1'b1; end
      if (c == 1) begin addr[1][31:0] = 32'h40; rd[1][0] = 1'b1; end
      if (c == 2) rd[1][1] = 1'b0;
      chk($sformatf("abort c%0d", c), 64'(valid[1]), (c == 7) ? 64'h1 : 64'h0);
      if (c == 7) rd[1][0] = 1'b0;
      tick();
    end
    chk("abort data", rdata[1], 64'h0000_0000_0102_0304);

    // LATENCY=3: reset in WAIT kills an uncommitted write.
    addr[1][31:0] = 32'h40; wdata[1][31:0] = 32'hFFFF_FFFF; sz[1] = 4'b0010;
    wr[1][0] = 1'b1;
    tick(); tick();
    rst_n[1] = 1'b0;
    #1;
    chk("mid rst valid", 64'(valid[1]), 64'h0);
    chk("mid rst data", rdata[1], 64'h0);
    wr[1] = 2'b00;
    tick(); tick();
    rst_n[1] = 1'b1;
    tick();
    access(1, 0, 0, 0, 32'h40, 32'h0, 2'b00, 4, "l3 rd after rst");
    chk("no commit", rdata[1][31:0], 64'h0102_0304);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
